// File: rtl/audio_sched_pkg.sv
// Shared types and default sizing for the tone-channel beat scheduler.
// Holds the scheduler state enum plus loop/effect length and width constants.
package audio_sched_pkg;

    localparam int DEF_BEAT_W   = 12;
    localparam int DEF_LOOP_LEN = 1200;
    localparam int DEF_NUM_SFX  = 4;
    localparam int DEF_SFX_LEN  = 16;
    localparam int DEF_ID_W     = 2;
    localparam int DEF_SB_W     = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUSIC  = 2'd1,
        SFX    = 2'd2,
        PAUSED = 2'd3
    } sched_state_t;

endpackage

// File: rtl/sfx_prio_arbiter.sv
// Combinational fixed-priority arbiter: lowest asserted request index wins.
// Ports: req (in), gnt one-hot (out), id encoded winner (out), any_req (out).
module sfx_prio_arbiter #(
    parameter int NUM_SFX = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_SFX-1:0] req,
    output logic [NUM_SFX-1:0] gnt,
    output logic [ID_W-1:0]    id,
    output logic               any_req
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        gnt = '0;
        id  = '0;
        for (int i = NUM_SFX - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                id     = ID_W'(i);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/audio_beat_scheduler.sv
// Beat-rate scheduler for the tone channel: music beat index plus effect arbitration.
// Ports: clk22, rst, music_en, pause, sfx_req in; sfx_ack, beat_num, music_mute,
// sfx_active, sfx_id, sfx_beat, loop_done out (all registered).
module audio_beat_scheduler
    import audio_sched_pkg::*;
#(
    parameter int BEAT_W   = DEF_BEAT_W,
    parameter int LOOP_LEN = DEF_LOOP_LEN,
    parameter int NUM_SFX  = DEF_NUM_SFX,
    parameter int SFX_LEN  = DEF_SFX_LEN,
    parameter int ID_W     = DEF_ID_W,
    parameter int SB_W     = DEF_SB_W
) (
    input  logic               clk22,
    input  logic               rst,
    input  logic               music_en,
    input  logic               pause,
    input  logic [NUM_SFX-1:0] sfx_req,
    output logic [NUM_SFX-1:0] sfx_ack,
    output logic [BEAT_W-1:0]  beat_num,
    output logic               music_mute,
    output logic               sfx_active,
    output logic [ID_W-1:0]    sfx_id,
    output logic [SB_W-1:0]    sfx_beat,
    output logic               loop_done
);

    sched_state_t       state, state_n;
    logic [NUM_SFX-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               any_req;

    logic [NUM_SFX-1:0] ack_n;
    logic [BEAT_W-1:0]  beat_n;
    logic               mute_n;
    logic               active_n;
    logic [ID_W-1:0]    id_n;
    logic [SB_W-1:0]    sb_n;
    logic               loop_n;
    logic               do_grant;

    sfx_prio_arbiter #(
        .NUM_SFX (NUM_SFX),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (sfx_req),
        .gnt     (gnt),
        .id      (gnt_id),
        .any_req (any_req)
    );

    always_comb begin
        state_n  = state;
        beat_n   = beat_num;
        ack_n    = '0;
        mute_n   = 1'b1;
        active_n = sfx_active;
        id_n     = sfx_id;
        sb_n     = sfx_beat;
        loop_n   = 1'b0;
        do_grant = 1'b0;

        if (pause) begin
            state_n = PAUSED;
        end else begin
            unique case (state)
                IDLE: begin
                    beat_n = '0;
                    if (any_req) begin
                        do_grant = 1'b1;
                    end else if (music_en) begin
                        state_n = MUSIC;
                        mute_n  = 1'b0;
                    end
                end
                MUSIC: begin
                    if (any_req) begin
                        // Music freezes on the grant edge.
                        do_grant = 1'b1;
                        if (!music_en) beat_n = '0;
                    end else if (!music_en) begin
                        beat_n  = '0;
                        state_n = IDLE;
                    end else begin
                        mute_n = 1'b0;
                        if (beat_num == BEAT_W'(LOOP_LEN)) begin
                            beat_n = '0;
                            loop_n = 1'b1;
                        end else begin
                            beat_n = beat_num + BEAT_W'(1);
                        end
                    end
                end
                SFX: begin
                    if (!music_en) beat_n = '0;
                    if (sfx_beat == SB_W'(SFX_LEN - 1)) begin
                        if (any_req) begin
                            do_grant = 1'b1;
                        end else begin
                            active_n = 1'b0;
                            if (music_en) begin
                                state_n = MUSIC;
                                mute_n  = 1'b0;
                            end else begin
                                state_n = IDLE;
                            end
                        end
                    end else begin
                        sb_n = sfx_beat + SB_W'(1);
                    end
                end
                PAUSED: begin
                    // Exit edge only restores the state; counting resumes next edge.
                    if (!music_en) beat_n = '0;
                    if (sfx_active) begin
                        state_n = SFX;
                    end else if (music_en) begin
                        state_n = MUSIC;
                        mute_n  = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        if (do_grant) begin
            state_n  = SFX;
            ack_n    = gnt;
            id_n     = gnt_id;
            sb_n     = '0;
            active_n = 1'b1;
        end
    end

    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beat_num   <= '0;
            sfx_ack    <= '0;
            sfx_active <= 1'b0;
            sfx_id     <= '0;
            sfx_beat   <= '0;
            music_mute <= 1'b1;
            loop_done  <= 1'b0;
        end else begin
            state      <= state_n;
            beat_num   <= beat_n;
            sfx_ack    <= ack_n;
            sfx_active <= active_n;
            sfx_id     <= id_n;
            sfx_beat   <= sb_n;
            music_mute <= mute_n;
            loop_done  <= loop_n;
        end
    end

endmodule

// File: tb/tb_audio_beat_scheduler.sv
// Self-checking bench for audio_beat_scheduler: directed scenarios then random
// traffic, compared every edge against a flag-based behavioural model.
module tb_audio_beat_scheduler;

    localparam int LOOP = 1200;
    localparam int SLEN = 16;
    localparam int NS   = 4;

    logic          clk22 = 1'b0;
    logic          rst;
    logic          music_en;
    logic          pause;
    logic [NS-1:0] sfx_req;
    logic [NS-1:0] sfx_ack;
    logic [11:0]   beat_num;
    logic          music_mute;
    logic          sfx_active;
    logic [1:0]    sfx_id;
    logic [3:0]    sfx_beat;
    logic          loop_done;

    int n_checks = 0;
    int n_err    = 0;

    // Model: the channel owner is described by flags, not a state code.
    bit            m_paused, m_active, m_music, m_mute, m_loop;
    int            m_beat, m_sb, m_id;
    logic [NS-1:0] m_ack;

    audio_beat_scheduler dut (
        .clk22      (clk22),
        .rst        (rst),
        .music_en   (music_en),
        .pause      (pause),
        .sfx_req    (sfx_req),
        .sfx_ack    (sfx_ack),
        .beat_num   (beat_num),
        .music_mute (music_mute),
        .sfx_active (sfx_active),
        .sfx_id     (sfx_id),
        .sfx_beat   (sfx_beat),
        .loop_done  (loop_done)
    );

    always #5 clk22 = ~clk22;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_paused = 0; m_active = 0; m_music = 0; m_mute = 1; m_loop = 0;
        m_beat = 0; m_sb = 0; m_id = 0; m_ack = '0;
    endtask

    task automatic grant(input int w);
        m_ack    = '0;
        m_ack[w] = 1'b1;
        m_id     = w;
        m_sb     = 0;
        m_active = 1;
        m_music  = 0;
        m_mute   = 1;
    endtask

    task automatic model_step();
        int w;
        w = -1;
        for (int i = NS - 1; i >= 0; i--) if (sfx_req[i]) w = i;
        m_ack  = '0;
        m_loop = 0;
        if (rst) begin
            model_reset();
        end else if (pause) begin
            m_paused = 1;
            m_mute   = 1;
        end else if (m_paused) begin
            m_paused = 0;
            if (!music_en) m_beat = 0;
            if (m_active) begin
                m_mute = 1;
            end else begin
                m_music = music_en;
                m_mute  = !music_en;
            end
        end else if (m_active) begin
            if (!music_en) m_beat = 0;
            if (m_sb == SLEN - 1) begin
                if (w >= 0) grant(w);
                else begin
                    m_active = 0;
                    m_music  = music_en;
                    m_mute   = !music_en;
                end
            end else begin
                m_sb++;
            end
        end else if (w >= 0) begin
            if (!music_en) m_beat = 0;
            grant(w);
        end else if (!music_en) begin
            m_music = 0;
            m_beat  = 0;
            m_mute  = 1;
        end else if (m_music) begin
            m_mute = 0;
            if (m_beat == LOOP) begin
                m_beat = 0;
                m_loop = 1;
            end else begin
                m_beat++;
            end
        end else begin
            m_music = 1;
            m_mute  = 0;
        end
    endtask

    task automatic compare(input string ph);
        chk({ph, ".ack"},    32'(sfx_ack),    32'(m_ack));
        chk({ph, ".beat"},   32'(beat_num),   32'(m_beat));
        chk({ph, ".mute"},   32'(music_mute), 32'(m_mute));
        chk({ph, ".active"}, 32'(sfx_active), 32'(m_active));
        chk({ph, ".id"},     32'(sfx_id),     32'(m_id));
        chk({ph, ".sbeat"},  32'(sfx_beat),   32'(m_sb));
        chk({ph, ".loop"},   32'(loop_done),  32'(m_loop));
    endtask

    // One edge: model advances on the same inputs, outputs sampled 1 time unit later;
    // requesters release once the model says they were acked.
    task automatic tick(input string ph);
        @(posedge clk22);
        model_step();
        #1;
        compare(ph);
        sfx_req = sfx_req & ~m_ack;
    endtask

    task automatic chk_reset_vals(input string ph);
        chk({ph, ".ack"},    32'(sfx_ack),    0);
        chk({ph, ".beat"},   32'(beat_num),   0);
        chk({ph, ".mute"},   32'(music_mute), 1);
        chk({ph, ".active"}, 32'(sfx_active), 0);
        chk({ph, ".id"},     32'(sfx_id),     0);
        chk({ph, ".sbeat"},  32'(sfx_beat),   0);
        chk({ph, ".loop"},   32'(loop_done),  0);
    endtask

    initial begin
        int k;
        rst = 1; music_en = 0; pause = 0; sfx_req = '0;
        model_reset();
        #1;
        chk_reset_vals("rst0");
        tick("rst_hold");
        tick("rst_hold");
        rst = 0;
        music_en = 1;

        // Music from reset and loop wrap.
        tick("mus_first");
        chk("first_beat", 32'(beat_num), 0);
        chk("first_mute", 32'(music_mute), 0);
        for (k = 0; k < 1300 && m_beat != LOOP; k++) tick("mus_run");
        chk("reach_loop", 32'(beat_num), LOOP);
        tick("wrap");
        chk("wrap_beat", 32'(beat_num), 0);
        chk("wrap_loop", 32'(loop_done), 1);
        tick("after_wrap");
        chk("wrap_pulse_end", 32'(loop_done), 0);

        // Single effect over frozen music.
        for (k = 0; k < 200 && m_beat != 100; k++) tick("to100");
        chk("reach_100", 32'(beat_num), 100);
        sfx_req = 4'b0100;
        tick("grant2");
        chk("ack2", 32'(sfx_ack), 32'h4);
        chk("id2", 32'(sfx_id), 2);
        for (k = 0; k < 40 && m_active; k++) tick("sfx2");
        chk("sfx2_end_active", 32'(sfx_active), 0);
        chk("sfx2_end_beat", 32'(beat_num), 100);
        tick("resume");
        chk("resume_beat", 32'(beat_num), 101);

        // Two simultaneous requesters, back to back.
        sfx_req = 4'b1010;
        tick("grant1");
        chk("ack1", 32'(sfx_ack), 32'h2);
        for (k = 0; k < 40 && m_ack[3] == 1'b0; k++) tick("sfx1");
        chk("ack3", 32'(sfx_ack), 32'h8);
        chk("ack3_sbeat", 32'(sfx_beat), 0);
        chk("ack3_id", 32'(sfx_id), 3);

        // Pause mid-effect with a pending requester.
        for (k = 0; k < 40 && m_sb != 5; k++) tick("to_sb5");
        pause = 1;
        sfx_req[0] = 1'b1;
        for (int p = 0; p < 10; p++) tick("paused");
        chk("pause_sbeat", 32'(sfx_beat), 5);
        pause = 0;
        for (k = 0; k < 60 && m_ack[0] == 1'b0; k++) tick("after_pause");
        chk("ack0", 32'(sfx_ack), 32'h1);

        // music_en drops during an effect.
        for (k = 0; k < 40 && m_sb != 8; k++) tick("to_sb8");
        music_en = 0;
        for (k = 0; k < 40 && m_active; k++) tick("no_music");
        chk("idle_mute", 32'(music_mute), 1);
        chk("idle_beat", 32'(beat_num), 0);
        tick("idle_stay");

        // Asynchronous reset mid-effect.
        music_en = 1;
        sfx_req = 4'b0010;
        for (k = 0; k < 40 && !(m_active && m_sb == 7); k++) tick("to_sb7");
        chk("reach_sb7", 32'(sfx_beat), 7);
        #2;
        rst = 1;
        sfx_req = '0;
        #1;
        model_reset();
        chk_reset_vals("async_rst");
        @(negedge clk22);
        rst = 0;
        tick("post_rst");
        tick("post_rst");

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            music_en = ($urandom % 16) != 0;
            pause    = ($urandom % 12) == 0;
            rst      = ($urandom % 700) == 0;
            for (int b = 0; b < NS; b++) begin
                if (!sfx_req[b] && ($urandom % 10) == 0) sfx_req[b] = 1'b1;
                else if (sfx_req[b] && ($urandom % 40) == 0) sfx_req[b] = 1'b0;
            end
            tick("rand");
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/audio_beat_scheduler.md
Name: audio_beat_scheduler

Overview:
- Beat-rate scheduler for the single tone channel (music ROM → note_gen → speaker_control).
- Owns the background-music beat index (replaces the free-running ibeatNum counter in top).
- Arbitrates NUM_SFX sound-effect requesters onto the same channel and mutes/freezes the music while an effect plays.
- Runs on clk22; top uses beat_num, sfx_id/sfx_beat and music_mute to select the tone fed to note_gen.

Parameters:
- BEAT_W, 12, width of the music beat index.
- LOOP_LEN, 1200, last beat index of the music loop (counts 0..LOOP_LEN inclusive).
- NUM_SFX, 4, number of sound-effect requesters.
- SFX_LEN, 16, beats per effect (power of 2).
- ID_W, 2, clog2(NUM_SFX).
- SB_W, 4, clog2(SFX_LEN).

Ports:
- Interface (already decided): reset rst, asynchronous, active-high; clock clk22.
- clk22  in  1  beat clock.
- rst  in  1  asynchronous active-high reset.
- music_en  in  1  background music enable (level, sync to clk22).
- pause  in  1  freeze all sequencing (level).
- sfx_req  in  NUM_SFX  per-requester effect request; held until acked.
- sfx_ack  out  NUM_SFX  one-cycle grant pulse per requester.
- beat_num  out  BEAT_W  music beat index to music ROM.
- music_mute  out  1  1 = music tone must not reach note_gen.
- sfx_active  out  1  an effect owns the channel.
- sfx_id  out  ID_W  index of the granted effect.
- sfx_beat  out  SB_W  beat within the current effect.
- loop_done  out  1  one-cycle pulse on music wrap.

Behaviour:
- Reset values: state IDLE, beat_num 0, sfx_ack 0, sfx_active 0, sfx_id 0, sfx_beat 0, music_mute 1, loop_done 0. Reset mid-operation aborts any effect immediately; no ack is pending afterwards.
- All outputs are registered; a change on an input is visible after the next clk22 edge.
- States: IDLE, MUSIC, SFX, PAUSED. Priority at each edge: rst > pause > SFX grant/continue > music_en.
- IDLE:
  - any sfx_req → SFX (grant).
  - else music_en → MUSIC.
  - beat_num is held at 0.
- MUSIC:
  - beat_num increments by 1 per edge.
  - At beat_num==LOOP_LEN it goes to 0 and loop_done=1 for that cycle.
  - music_en=0 → beat_num 0, IDLE.
  - any sfx_req → SFX; beat_num does not increment on the grant edge.
- Grant:
  - The lowest-index asserted req wins (fixed priority, no preemption).
  - On the grant edge: sfx_ack[i]=1 for exactly one cycle, sfx_id=i, sfx_beat=0, sfx_active=1, music_mute=1.
  - A req dropped before it is acked is lost; requests are not latched.
- SFX:
  - sfx_beat increments per edge; beat_num is frozen, or forced to 0 if music_en=0.
  - At the edge where sfx_beat==SFX_LEN-1: if any req is asserted, grant back-to-back (new ack, sfx_beat 0). Otherwise sfx_active=0 and go to MUSIC (music_en=1, music_mute 0, beat_num resumes at frozen+1 on the following edge) or IDLE.
  - A req still high from the just-finished requester is treated as a new request.
- PAUSED:
  - Entered from any state when pause=1.
  - Holds beat_num, sfx_beat, sfx_id and sfx_active; issues no acks; music_mute=1; loop_done=0.
  - On pause=0: return to SFX if sfx_active, else MUSIC if music_en, else IDLE.
  - music_en=0 while paused clears beat_num on exit.
- music_mute = 1 in every state except MUSIC.
- Arithmetic: beat_num is compared to LOOP_LEN with == (never exceeds it); sfx_beat wraps naturally at SFX_LEN.

Decomposition:
- Package audio_sched_pkg holds:
  - state enum (IDLE, MUSIC, SFX, PAUSED);
  - LOOP_LEN, SFX_LEN and NUM_SFX defaults;
  - the width constants.
- One sub-module, sfx_prio_arbiter: combinational fixed-priority grant over sfx_req, producing a one-hot grant, encoded id, and any_req.
- The FSM, counters and registered outputs stay in audio_beat_scheduler.

Test Plan:
- Reset released, music_en=1 → beat_num 0,1,2,… each edge, music_mute 0 from the first edge. At beat_num=1200 the next value is 0 with loop_done=1 for exactly one cycle.
- sfx_req[2] raised and held while beat_num=100:
  - ack[2] one cycle, sfx_id=2, sfx_active=1, music_mute=1;
  - sfx_beat runs 0..15 while beat_num stays 100;
  - then sfx_active=0, music_mute=0, and beat_num goes to 101 on the next edge.
- sfx_req[1] and sfx_req[3] asserted together and held → ack[1] first. After sfx_beat=15, ack[3] fires on the next edge with sfx_id=3 and sfx_beat=0, with no music cycle between the two effects.
- pause=1 at sfx_beat=5 for 10 edges, with sfx_req[0] also asserted → all outputs hold, no ack, music_mute=1. After pause=0 the next sfx_beat is 6; req[0] is acked only after the current effect ends.
- music_en dropped at sfx_beat=8 → the effect completes to 15, beat_num is 0 during the effect, and the state ends in IDLE with music_mute=1.
- rst asserted asynchronously mid-effect (sfx_beat=7) → all outputs go to reset values immediately, without waiting for a clk22 edge.
